// File: rtl/dmem_ctrl.sv
// Data-memory stage between EX and WB: RISC-V byte/half/word loads and stores,
// with error detection and a configurable number of wait states per access.
module dmem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o
);

  localparam int WORDS = DEPTH / 4;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        do_access;

  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata;

  logic        a_we;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_size;
  logic [32:0] end_addr;
  logic        a_err;
  logic [AW-1:0] idx;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wshift, rword, rshift, load_data;

  logic [31:0] mem [WORDS];

  assign ready_o = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          do_access = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (req_i && ready_o) begin
      r_we    <= we_i;
      r_f3    <= funct3_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
    end
  end

  // In IDLE the access (zero wait states) uses the live request; in BUSY the captured one.
  always_comb begin
    a_we    = (state == IDLE) ? we_i     : r_we;
    a_f3    = (state == IDLE) ? funct3_i : r_f3;
    a_addr  = (state == IDLE) ? addr_i   : r_addr;
    a_wdata = (state == IDLE) ? wdata_i  : r_wdata;

    case (a_f3[1:0])
      2'b00:   a_size = 3'd1;
      2'b01:   a_size = 3'd2;
      default: a_size = 3'd4;
    endcase
    end_addr = {1'b0, a_addr} + {30'b0, a_size};

    a_err = (end_addr > 33'(DEPTH))
          || (a_f3 inside {3'b011, 3'b110, 3'b111})
          || (a_we && a_f3[2])
          || (a_f3[1:0] == 2'b01 && a_addr[0])
          || (a_f3[1:0] == 2'b10 && a_addr[1:0] != 2'b00);

    idx = a_addr[AW+1:2];
    off = a_addr[1:0];
    case (a_f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    wshift = a_wdata << {off, 3'b000};

    rword  = mem[idx];
    rshift = rword >> {off, 3'b000};
    case (a_f3)
      3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_data = {24'b0, rshift[7:0]};
      3'b101:  load_data = {16'b0, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  // Reset on the performing edge aborts the access, so it also blocks the write.
  always_ff @(posedge clk) begin
    if (do_access && a_we && !a_err && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      rdata_o <= '0;
      addr_o  <= '0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= do_access;
      if (do_access) begin
        addr_o  <= a_addr;
        err_o   <= a_err;
        rdata_o <= (a_err || a_we) ? 32'b0 : load_data;
      end
    end
  end

endmodule
